// File: rtl/keypad_matrix_scanner.sv
`timescale 1ns/1ps
// keypad_matrix_scanner
//
// Scans a ROWS x COLS key matrix one column at a time. Each column is driven
// low for SETTLE cycles, then the active-low rows are sampled into a raw frame.
// After the last column the whole frame is debounced: once DEBOUNCE
// consecutive identical frames have been seen and the frame differs from the
// debounced key map, the map is updated and every changed key is walked in
// index order (column-major), pushing press/release events into a small FIFO.
//
// Ports:
//   clk       system clock
//   rstn      asynchronous active-low reset
//   col_oe    per-column output enable; 1 = pad drives that column low
//   row_in    raw row levels (pulled up); 0 = key closed on driven column
//   ev_valid  event available at FIFO head (registered)
//   ev_ready  consumer accepts the head event when ev_valid & ev_ready
//   ev_press  head event polarity, 1 = press, 0 = release (registered)
//   ev_code   head event key {row index, column index} (registered)
//   key_map   debounced key state, bit c*ROWS+r set when key (r,c) is down
//   multi     two or more keys down in key_map (one cycle behind key_map)
//   overflow  sticky: an event was dropped because the FIFO was full
//   clr_ovf   single-cycle clear of overflow
module keypad_matrix_scanner #(
  parameter  int ROWS       = 5,
  parameter  int COLS       = 5,
  parameter  int SETTLE     = 4,
  parameter  int DEBOUNCE   = 3,
  parameter  int FIFO_DEPTH = 4,
  localparam int RW         = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int CW         = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic                 clk,
  input  logic                 rstn,
  output logic [COLS-1:0]      col_oe,
  input  logic [ROWS-1:0]      row_in,
  output logic                 ev_valid,
  input  logic                 ev_ready,
  output logic                 ev_press,
  output logic [RW+CW-1:0]     ev_code,
  output logic [ROWS*COLS-1:0] key_map,
  output logic                 multi,
  output logic                 overflow,
  input  logic                 clr_ovf
);

  localparam int NK   = ROWS * COLS;
  localparam int IW   = (NK > 1) ? $clog2(NK) : 1;
  localparam int SW   = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int DW   = $clog2(DEBOUNCE + 1);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CNTW = AW + 1;
  localparam int EW   = 1 + RW + CW;

  typedef enum logic [1:0] {
    S_DRIVE  = 2'd0,
    S_SAMPLE = 2'd1,
    S_EVAL   = 2'd2,
    S_EMIT   = 2'd3
  } state_t;

  // True when more than one bit of v is set: clearing the lowest set bit
  // leaves something behind.
  function automatic logic more_than_one(input logic [NK-1:0] v);
    return |(v & (v - NK'(1)));
  endfunction

  state_t          state, state_next;
  logic [CW-1:0]   col, col_next;
  logic [SW-1:0]   settle, settle_next;
  logic [IW-1:0]   idx, idx_next;
  logic [RW-1:0]   erow, erow_next;
  logic [COLS-1:0] col_oe_next;

  logic [NK-1:0]   raw, prev, diff;
  logic [DW-1:0]   stable_cnt, stable_upd;
  logic            take_frame;

  logic            push;
  logic [EW-1:0]   push_entry;

  // Debounce counter value as it will be after this EVAL cycle; the EMIT
  // decision uses the updated count, not the registered one.
  always_comb begin
    stable_upd = stable_cnt;
    if (raw != prev) begin
      stable_upd = '0;
    end else if (stable_cnt != DW'(DEBOUNCE)) begin
      stable_upd = stable_cnt + DW'(1);
    end
  end

  assign take_frame = (stable_upd >= DW'(DEBOUNCE)) && (raw != key_map);

  // key_map already holds the new state while EMIT runs, so its bit is the
  // event polarity. col doubles as the column index of the walk.
  assign push_entry = {key_map[idx], erow, col};

  always_comb begin
    state_next  = state;
    col_next    = col;
    settle_next = settle;
    idx_next    = idx;
    erow_next   = erow;
    push        = 1'b0;
    col_oe_next = '0;
    unique case (state)
      S_DRIVE: begin
        if (settle == SW'(SETTLE - 1)) begin
          settle_next = '0;
          state_next  = S_SAMPLE;
        end else begin
          settle_next = settle + SW'(1);
        end
      end
      S_SAMPLE: begin
        if (col == CW'(COLS - 1)) begin
          col_next   = '0;
          state_next = S_EVAL;
        end else begin
          col_next   = col + CW'(1);
          state_next = S_DRIVE;
        end
      end
      S_EVAL: begin
        col_next   = '0;
        idx_next   = '0;
        erow_next  = '0;
        state_next = take_frame ? S_EMIT : S_DRIVE;
      end
      S_EMIT: begin
        push = diff[idx];
        if (idx == IW'(NK - 1)) begin
          state_next = S_DRIVE;
          col_next   = '0;
          idx_next   = '0;
          erow_next  = '0;
        end else begin
          idx_next = idx + IW'(1);
          if (erow == RW'(ROWS - 1)) begin
            erow_next = '0;
            col_next  = col + CW'(1);
          end else begin
            erow_next = erow + RW'(1);
          end
        end
      end
      default: state_next = S_DRIVE;
    endcase
    // col_oe is registered from the next state so it lines up with the state
    // it belongs to and stays glitch-free at the pads.
    for (int c = 0; c < COLS; c++) begin
      col_oe_next[c] = ((state_next == S_DRIVE) || (state_next == S_SAMPLE)) &&
                       (col_next == CW'(c));
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= S_DRIVE;
      col    <= '0;
      settle <= '0;
      idx    <= '0;
      erow   <= '0;
      col_oe <= '0;
    end else begin
      state  <= state_next;
      col    <= col_next;
      settle <= settle_next;
      idx    <= idx_next;
      erow   <= erow_next;
      col_oe <= col_oe_next;
    end
  end

  // ---- frame capture / debounce stage ----
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      raw        <= '0;
      prev       <= '0;
      stable_cnt <= '0;
      key_map    <= '0;
      multi      <= 1'b0;
    end else begin
      if (state == S_SAMPLE) begin
        for (int c = 0; c < COLS; c++) begin
          if (col == CW'(c)) begin
            raw[c*ROWS +: ROWS] <= ~row_in;
          end
        end
      end
      if (state == S_EVAL) begin
        stable_cnt <= stable_upd;
        prev       <= raw;
        if (take_frame) begin
          key_map <= raw;
        end
      end
      multi <= more_than_one(key_map);
    end
  end

  // Change mask for the EMIT walk; only meaningful after an EVAL that took a
  // frame, so it needs no reset.
  always_ff @(posedge clk) begin
    if ((state == S_EVAL) && take_frame) begin
      diff <= raw ^ key_map;
    end
  end

  // ---- event FIFO stage ----
  logic [EW-1:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, wr_ptr_next, rd_ptr, rd_ptr_next;
  logic [CNTW-1:0] count, count_next;
  logic            pop, full, push_ok, drop;
  logic [EW-1:0]   head_next;

  always_comb begin
    pop         = ev_valid & ev_ready;
    full        = (count == CNTW'(FIFO_DEPTH));
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    push_ok     = push & (~full | pop);
    drop        = push & full & ~pop;
    wr_ptr_next = push_ok ? wr_ptr + AW'(1) : wr_ptr;
    rd_ptr_next = pop ? rd_ptr + AW'(1) : rd_ptr;
    count_next  = count + CNTW'(push_ok) - CNTW'(pop);
    // The entry being written this cycle becomes the head when the FIFO is
    // (or is about to be) empty; bypass it since mem is not yet updated.
    if (push_ok && (rd_ptr_next == wr_ptr)) begin
      head_next = push_entry;
    end else begin
      head_next = mem[rd_ptr_next];
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_entry;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      ev_valid <= 1'b0;
      ev_press <= 1'b0;
      ev_code  <= '0;
      overflow <= 1'b0;
    end else begin
      wr_ptr              <= wr_ptr_next;
      rd_ptr              <= rd_ptr_next;
      count               <= count_next;
      ev_valid            <= (count_next != '0);
      {ev_press, ev_code} <= head_next;
      // A drop in the same cycle as clr_ovf keeps the flag set.
      overflow            <= drop | (overflow & ~clr_ovf);
    end
  end

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
`timescale 1ns/1ps
// Self-checking bench for keypad_matrix_scanner (default 5x5 geometry).
// A key matrix held in the bench drives row_in through the column enables;
// expected events come from comparing successive stable key patterns.
module tb_keypad_matrix_scanner;

  localparam int ROWS  = 5;
  localparam int COLS  = 5;
  localparam int NK    = ROWS * COLS;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            rstn;
  logic [COLS-1:0] col_oe;
  logic [ROWS-1:0] row_in;
  logic            ev_valid;
  logic            ev_ready;
  logic            ev_press;
  logic [5:0]      ev_code;
  logic [NK-1:0]   key_map;
  logic            multi;
  logic            overflow;
  logic            clr_ovf;

  logic [NK-1:0]   keys;

  always #5 clk = ~clk;

  keypad_matrix_scanner #(
    .ROWS(ROWS), .COLS(COLS), .SETTLE(4), .DEBOUNCE(3), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rstn(rstn), .col_oe(col_oe), .row_in(row_in),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_press(ev_press),
    .ev_code(ev_code), .key_map(key_map), .multi(multi),
    .overflow(overflow), .clr_ovf(clr_ovf)
  );

  // Passive matrix: a row reads low when a closed key sits on a driven column.
  always_comb begin
    row_in = '1;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if (col_oe[c] && keys[c*ROWS + r]) row_in[r] = 1'b0;
      end
    end
  end

  typedef logic [6:0] ev_t;  // {press, row[2:0], col[2:0]}
  ev_t got_q[$];
  ev_t exp_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;
  logic [NK-1:0] model_map;

  always @(negedge clk) begin
    if (rstn && ev_valid && ev_ready) got_q.push_back({ev_press, ev_code});
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // Reference: going from one debounced pattern to another yields one event
  // per changed key, in ascending column-major index order.
  function automatic void model_events(input logic [NK-1:0] old_m, input logic [NK-1:0] new_m);
    for (int i = 0; i < NK; i++) begin
      if (old_m[i] != new_m[i]) exp_q.push_back({new_m[i], 3'(i % ROWS), 3'(i / ROWS)});
    end
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic compare_events(input string tag);
    int n;
    check({tag, " event count"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s event %0d", tag, i), got_q[i], exp_q[i]);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  typedef struct {
    logic [NK-1:0] pat;
    logic [NK-1:0] exp_map;
    logic          exp_multi;
    int            exp_nev;
    int            hold;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    logic [NK-1:0] pat;

    vecs[0] = '{25'h0020000, 25'h0020000, 1'b0, 1, 155};  // (2,3) from reset
    vecs[1] = '{25'h0000000, 25'h0000000, 1'b0, 1, 300};  // release (2,3)
    vecs[2] = '{25'h0000810, 25'h0000810, 1'b1, 2, 300};  // (4,0) + (1,2)
    vecs[3] = '{25'h0000800, 25'h0000800, 1'b0, 1, 300};  // release (4,0)
    vecs[4] = '{25'h1001001, 25'h1001001, 1'b1, 4, 300};  // mixed press/release
    vecs[5] = '{25'h0000000, 25'h0000000, 1'b0, 3, 300};  // all up

    rstn      = 1'b0;
    keys      = '0;
    ev_ready  = 1'b1;
    clr_ovf   = 1'b0;
    model_map = '0;
    cycles(3);
    check("reset col_oe", col_oe, 0);
    check("reset ev_valid", ev_valid, 0);
    check("reset key_map", key_map, 0);
    check("reset multi", multi, 0);
    check("reset overflow", overflow, 0);
    @(negedge clk);
    rstn = 1'b1;
    cycles(1);

    // Table-driven press/release patterns.
    for (int v = 0; v < 6; v++) begin
      keys = vecs[v].pat;
      model_events(model_map, vecs[v].pat);
      model_map = vecs[v].pat;
      cycles(vecs[v].hold);
      check($sformatf("vec%0d key_map", v), key_map, vecs[v].exp_map);
      check($sformatf("vec%0d multi", v), multi, vecs[v].exp_multi);
      check($sformatf("vec%0d events seen", v), got_q.size(), vecs[v].exp_nev);
      if (v == 0 && got_q.size() > 0) check("single press head", got_q[0], 7'b1_010_011);
      if (v == 2 && got_q.size() > 1) begin
        check("simultaneous first", got_q[0], 7'b1_100_000);
        check("simultaneous second", got_q[1], 7'b1_001_010);
      end
      compare_events($sformatf("vec%0d", v));
      check($sformatf("vec%0d overflow", v), overflow, 0);
    end

    // Bounce on (0,0): period 20 never yields four equal frames in a row.
    for (int k = 0; k < 20; k++) begin
      keys[0] = ~keys[0];
      cycles(10);
    end
    check("bounce no events", got_q.size(), 0);
    keys = 25'h1;
    model_events(model_map, keys);
    model_map = keys;
    cycles(300);
    check("bounce settled key_map", key_map, 25'h1);
    compare_events("bounce press");
    keys = '0;
    model_events(model_map, keys);
    model_map = keys;
    cycles(300);
    compare_events("bounce release");

    // Overflow: six presses in one frame with the consumer stalled.
    ev_ready = 1'b0;
    pat = 25'h1E00003;
    keys = pat;
    model_events(model_map, pat);
    model_map = pat;
    while (exp_q.size() > DEPTH) void'(exp_q.pop_back());
    cycles(300);
    check("overflow set", overflow, 1);
    check("overflow key_map", key_map, pat);
    check("overflow head valid", ev_valid, 1);
    clr_ovf = 1'b1;
    cycles(1);
    clr_ovf = 1'b0;
    check("overflow cleared", overflow, 0);
    ev_ready = 1'b1;
    cycles(10);
    compare_events("overflow drain");
    check("overflow drained", ev_valid, 0);

    // Async reset mid-EMIT with two releases queued.
    ev_ready = 1'b0;
    keys = '0;
    t = 0;
    while (!ev_valid && t < 400) begin
      cycles(1);
      t++;
    end
    check("reset-test event queued", ev_valid, 1);
    cycles(2);
    #3 rstn = 1'b0;
    #1;
    check("async reset ev_valid", ev_valid, 0);
    check("async reset col_oe", col_oe, 0);
    check("async reset key_map", key_map, 0);
    check("async reset multi", multi, 0);
    cycles(2);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    check("restart at column 0", col_oe, 5'b00001);
    got_q.delete();
    exp_q.delete();
    model_map = '0;
    ev_ready = 1'b1;
    cycles(150);
    check("queue discarded by reset", got_q.size(), 0);
    got_q.delete();

    // Randomised patterns against the pattern-to-pattern model.
    for (int k = 0; k < 10; k++) begin
      pat = NK'($urandom & $urandom & $urandom);
      if (k == 9) pat = '0;
      keys = pat;
      model_events(model_map, pat);
      model_map = pat;
      cycles(300);
      check($sformatf("rand%0d key_map", k), key_map, pat);
      check($sformatf("rand%0d multi", k), multi, ($countones(pat) >= 2) ? 1 : 0);
      compare_events($sformatf("rand%0d", k));
      check($sformatf("rand%0d overflow", k), overflow, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
